bus_demux: RTL

Registered 1-to-8 transaction demultiplexer that routes a single core-side load/store request to one of eight target ports and returns that target's response to the core. It sits between the core's data-memory interface and the peripheral/memory targets, and is the distributing counterpart of the 8-way result-select mux. A three-state FSM handles the flow. A per-transaction timeout guarantees the core never hangs on a silent target.

---
 rtl/bus_demux.sv | 119 +++++++++++
 1 files changed

// File: rtl/bus_demux.sv
// bus_demux: registered 1-to-8 load/store demultiplexer.
//
// One core-side request is latched in IDLE. It is presented to exactly one target
// (one-hot tgt_valid) during ISSUE. The selected target's completion, or a timeout,
// produces a single-cycle response pulse in RESP.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   req_valid/ready    core request handshake
//   req_sel            target index 0..7
//   req_we/addr/wdata/wstrb
//                      request attributes, latched on accept
//   rsp_valid          one-cycle response pulse
//   rsp_rdata/err      response data/error, held until the next response
//   tgt_valid          one-hot request to target i
//   tgt_we/addr/wdata/wstrb
//                      shared, registered copies of the latched request
//   tgt_ready          per-target completion
//   tgt_rdata          flattened read data, target i at [i*DATA_W +: DATA_W]
module bus_demux #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_sel,
  input  logic                req_we,
  input  logic [DATA_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [3:0]          req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [7:0]          tgt_valid,
  output logic                tgt_we,
  output logic [DATA_W-1:0]   tgt_addr,
  output logic [DATA_W-1:0]   tgt_wdata,
  output logic [3:0]          tgt_wstrb,
  input  logic [7:0]          tgt_ready,
  input  logic [8*DATA_W-1:0] tgt_rdata
);

  // At least one bit so that TIMEOUT=0 (timeout disabled) still elaborates.
  localparam int CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          state;
  logic [2:0]      sel_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      sel_q     <= '0;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      tgt_valid <= '0;
      tgt_we    <= 1'b0;
      tgt_addr  <= '0;
      tgt_wdata <= '0;
      tgt_wstrb <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          // req_ready is registered; it stays low in the first cycle after reset release.
          if (req_valid && req_ready) begin
            sel_q     <= req_sel;
            tgt_we    <= req_we;
            tgt_addr  <= req_addr;
            tgt_wdata <= req_wdata;
            tgt_wstrb <= req_wstrb;
            cnt_q     <= '0;
            tgt_valid <= 8'b1 << req_sel;
            req_ready <= 1'b0;
            state     <= StIssue;
          end else begin
            req_ready <= 1'b1;
          end
        end
        StIssue: begin
          // Ready is checked first, so it wins over a timeout expiring in the same cycle.
          if (tgt_ready[sel_q]) begin
            rsp_rdata <= tgt_we ? '0 : tgt_rdata[sel_q*DATA_W +: DATA_W];
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            tgt_valid <= '0;
            state     <= StResp;
          end else if (TIMEOUT != 0 && cnt_q == CntMax) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            tgt_valid <= '0;
            state     <= StResp;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          req_ready <= 1'b1;
          state     <= StIdle;
        end
        default: begin
          tgt_valid <= '0;
          req_ready <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule
